ip_decoder: RTL and testbench
=============================

IP_DECODER -- requirements
Module: ip_decoder

Interface
REQ-001 SHALL have parameter DROP_ON_ERR, default 1; when 1, payload of a packet flagged err is not forwarded (wr_en held 0).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port data_in, input, 32, received IPv4 word stream, header first, big-endian field order.
REQ-005 SHALL have port data_av, input, 1, data_in valid this cycle; no backpressure.
REQ-006 SHALL have ports version[3:0], IHL[3:0], type_of_ser[7:0], total_len[15:0], identification[15:0], flag[2:0], frag_offset[12:0], time_to_live[7:0], protocol[7:0], src_ip[31:0], dest_ip[31:0], all outputs, holding the latched header fields of the current/last packet.
REQ-007 SHALL have port len_out, output, 16, payload bytes = total_len - 4*IHL.
REQ-008 SHALL have port pkg_data, output, 32, payload word.
REQ-009 SHALL have port wr_en, output, 1, pkg_data valid.
REQ-010 SHALL have port hdr_valid, output, 1, one-cycle pulse when the last header word is accepted.
REQ-011 SHALL have port checksum_ok, output, 1, header checksum verdict, valid from the hdr_valid pulse until the next packet starts.
REQ-012 SHALL have port err, output, 1, sticky per packet: format or checksum failure.
REQ-013 SHALL have port fin, output, 1, one-cycle pulse at packet end.

Function
REQ-014 SHALL implement states IDLE, HDR, OPT, DATA, FIN; a word is accepted only in a cycle with data_av=1; data_av=0 stalls every state except FIN with no field change and wr_en=0.
REQ-015 IDLE: accepted word is header word 1; latch version, IHL, type_of_ser, total_len; clear err and checksum_ok; go to HDR with hdr_cnt=1.
REQ-016 HDR: words 2..5 latch identification/flag/frag_offset, time_to_live/protocol (checksum field only summed), src_ip, dest_ip respectively.
REQ-017 After word 5: IHL>5 -> OPT, consuming IHL-5 option words (summed, not output); else header complete.
REQ-018 Header complete: pulse hdr_valid; go to DATA if len_out>0, else FIN.
REQ-019 Format error on word 1 (version!=4, IHL<5, or total_len<4*IHL): set err; header still parsed to its end for sequencing; len_out forced to 0, so the packet goes to FIN after the header.
REQ-020 Checksum: 32-bit one's-complement accumulation of all header words incl. checksum field and options, folded to 16 bits with end-around carry; checksum_ok=1 iff the folded sum is 16'hFFFF; mismatch sets err.
REQ-021 DATA: each accepted word -> pkg_data<=data_in, wr_en=1 on the next cycle (latency 1); bytes_left loaded with len_out at header completion, decremented by 4 per word, saturating at 0 when <4.
REQ-022 When bytes_left reaches 0, go to FIN; the final word is passed whole, with unused low bytes unmodified.
REQ-023 FIN lasts exactly one cycle with fin=1, then IDLE; a data_av word arriving in FIN is discarded; upstream guarantees a gap of at least one cycle between packets.
REQ-024 With DROP_ON_ERR=1 and err=1, DATA still consumes payload words but holds wr_en=0 and pkg_data unchanged.
REQ-025 Header field outputs SHALL hold their values until overwritten by the next packet.

Reset
REQ-026 reset=0 SHALL asynchronously force IDLE, with outputs pkg_data=0, wr_en=0, fin=0, hdr_valid=0, err=0, checksum_ok=0, all header fields 0, len_out=0, bytes_left=0, hdr_cnt=0.
REQ-027 reset asserted mid-packet SHALL abandon the packet with no fin pulse; the first accepted word after release is treated as header word 1.

Configuration
REQ-028 Macro IP_DEC_CHECKSUM_EN defined: checksum accumulation and checking per REQ-020 are compiled in.
REQ-029 Macro IP_DEC_CHECKSUM_EN undefined: no accumulator logic; checksum_ok=1 at hdr_valid; err is driven only by format errors.

Verification
REQ-030 Header 45000020 with a correct checksum, src C0A80001, dest C0A80002, plus 3 payload words -> hdr_valid once, len_out=12, three wr_en pulses each 1 cycle after input, fin after 3rd, err=0.
REQ-031 Same packet with data_av toggling 1/0 every cycle -> identical outputs, wr_en only following valid words.
REQ-032 Header checksum field corrupted by +1 -> checksum_ok=0, err=1, no wr_en (DROP_ON_ERR=1), fin still pulses after 3 payload words.
REQ-033 IHL=6 (one option word), total_len=0x001A -> option word not output, len_out=2, one payload word, fin.
REQ-034 Word 1 = 65000014 (version 6) -> err=1 after word 1, fin after header, no wr_en; total_len=0x0014 -> len_out=0, fin directly after hdr_valid.
REQ-035 reset pulsed low during DATA of packet 1, then a full new packet sent -> all outputs 0 immediately on reset, no fin for packet 1, packet 2 decoded correctly.

Source files
------------

// File: rtl/ip_decoder.sv
// ip_decoder: IPv4 header parser that latches header fields and forwards payload words.
// Define IP_DEC_CHECKSUM_EN to compile in the header checksum accumulator and check.
module ip_decoder #(
  parameter int unsigned DROP_ON_ERR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        data_av,
  output logic [3:0]  version,
  output logic [3:0]  IHL,
  output logic [7:0]  type_of_ser,
  output logic [15:0] total_len,
  output logic [15:0] identification,
  output logic [2:0]  flag,
  output logic [12:0] frag_offset,
  output logic [7:0]  time_to_live,
  output logic [7:0]  protocol,
  output logic [31:0] src_ip,
  output logic [31:0] dest_ip,
  output logic [15:0] len_out,
  output logic [31:0] pkg_data,
  output logic        wr_en,
  output logic        hdr_valid,
  output logic        checksum_ok,
  output logic        err,
  output logic        fin
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_OPT,
    S_DATA,
    S_FIN
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic [3:0]  ver_q;
  logic [3:0]  ver_d;
  logic [3:0]  ihl_q;
  logic [3:0]  ihl_d;
  logic [7:0]  tos_q;
  logic [7:0]  tos_d;
  logic [15:0] tlen_q;
  logic [15:0] tlen_d;
  logic [15:0] id_q;
  logic [15:0] id_d;
  logic [2:0]  flag_q;
  logic [2:0]  flag_d;
  logic [12:0] frag_q;
  logic [12:0] frag_d;
  logic [7:0]  ttl_q;
  logic [7:0]  ttl_d;
  logic [7:0]  proto_q;
  logic [7:0]  proto_d;
  logic [31:0] src_q;
  logic [31:0] src_d;
  logic [31:0] dst_q;
  logic [31:0] dst_d;
  logic [15:0] len_q;
  logic [15:0] len_d;
  logic [15:0] bytes_left_q;
  logic [15:0] bytes_left_d;
  logic [3:0]  hdr_cnt_q;
  logic [3:0]  hdr_cnt_d;
  logic [31:0] pkg_data_q;
  logic [31:0] pkg_data_d;
  logic        wr_en_q;
  logic        wr_en_d;
  logic        hdr_valid_q;
  logic        hdr_valid_d;
  logic        chk_ok_q;
  logic        chk_ok_d;
  logic        err_q;
  logic        err_d;
  logic        fin_q;
  logic        fin_d;

  logic        sum_ok;
  logic        fmt_err;
  logic [15:0] in_hdr_bytes;
  logic [3:0]  word_no;
  logic [3:0]  hdr_words;
  logic        hdr_last;
  logic        data_last;
  logic        fwd;

  assign in_hdr_bytes = {10'h0, data_in[27:24], 2'b00};
  assign fmt_err = (data_in[31:28] != 4'd4)
                 | (data_in[27:24] < 4'd5)
                 | (data_in[15:0] < in_hdr_bytes);

  // A short IHL still walks the five fixed header words.
  assign hdr_words = (ihl_q < 4'd5) ? 4'd5 : ihl_q;
  assign word_no   = hdr_cnt_q + 4'd1;
  assign hdr_last  = (word_no == hdr_words);
  assign data_last = (bytes_left_q <= 16'd4);
  assign fwd       = !((DROP_ON_ERR != 0) && err_q);

`ifdef IP_DEC_CHECKSUM_EN
  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [31:0] word_sum;
  logic [31:0] acc_sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  assign word_sum = {16'h0, data_in[31:16]}
                  + {16'h0, data_in[15:0]};
  assign acc_sum  = acc_q + word_sum;

  // Two folds are enough: the first carry-out can never repeat.
  always_comb begin
    fold1  = {1'b0, acc_sum[31:16]}
           + {1'b0, acc_sum[15:0]};
    fold2  = fold1[15:0] + {15'h0, fold1[16]};
    sum_ok = (fold2 == 16'hFFFF);
  end

  always_comb begin
    acc_d = acc_q;
    if (data_av) begin
      unique case (1'b1)
        state_q == S_IDLE: acc_d = word_sum;
        state_q == S_HDR,
        state_q == S_OPT:  acc_d = acc_sum;
        default:           acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  assign sum_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    ver_d        = ver_q;
    ihl_d        = ihl_q;
    tos_d        = tos_q;
    tlen_d       = tlen_q;
    id_d         = id_q;
    flag_d       = flag_q;
    frag_d       = frag_q;
    ttl_d        = ttl_q;
    proto_d      = proto_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    bytes_left_d = bytes_left_q;
    hdr_cnt_d    = hdr_cnt_q;
    pkg_data_d   = pkg_data_q;
    chk_ok_d     = chk_ok_q;
    err_d        = err_q;
    wr_en_d      = 1'b0;
    hdr_valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (data_av) begin
          ver_d     = data_in[31:28];
          ihl_d     = data_in[27:24];
          tos_d     = data_in[23:16];
          tlen_d    = data_in[15:0];
          len_d     = fmt_err ? 16'd0
                    : data_in[15:0] - in_hdr_bytes;
          err_d     = fmt_err;
          chk_ok_d  = 1'b0;
          hdr_cnt_d = 4'd1;
          state_d   = S_HDR;
        end
      end

      S_HDR,
      S_OPT: begin
        if (data_av) begin
          hdr_cnt_d = word_no;
          if (state_q == S_HDR) begin
            case (hdr_cnt_q)
              4'd1: begin
                id_d   = data_in[31:16];
                flag_d = data_in[15:13];
                frag_d = data_in[12:0];
              end
              4'd2: begin
                ttl_d   = data_in[31:24];
                proto_d = data_in[23:16];
              end
              4'd3:    src_d = data_in;
              4'd4:    dst_d = data_in;
              default: ;
            endcase
          end
          if (hdr_last) begin
            hdr_valid_d  = 1'b1;
            chk_ok_d     = sum_ok;
            err_d        = err_q | ~sum_ok;
            bytes_left_d = len_q;
            state_d      = (len_q != 16'd0)
                         ? S_DATA : S_FIN;
          end else if (word_no == 4'd5) begin
            state_d = S_OPT;
          end
        end
      end

      S_DATA: begin
        if (data_av) begin
          bytes_left_d = data_last ? 16'd0
                       : bytes_left_q - 16'd4;
          if (fwd) begin
            wr_en_d    = 1'b1;
            pkg_data_d = data_in;
          end
          if (data_last) begin
            state_d = S_FIN;
          end
        end
      end

      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    fin_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ver_q        <= '0;
      ihl_q        <= '0;
      tos_q        <= '0;
      tlen_q       <= '0;
      id_q         <= '0;
      flag_q       <= '0;
      frag_q       <= '0;
      ttl_q        <= '0;
      proto_q      <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      bytes_left_q <= '0;
      hdr_cnt_q    <= '0;
      pkg_data_q   <= '0;
      wr_en_q      <= 1'b0;
      hdr_valid_q  <= 1'b0;
      chk_ok_q     <= 1'b0;
      err_q        <= 1'b0;
      fin_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ver_q        <= ver_d;
      ihl_q        <= ihl_d;
      tos_q        <= tos_d;
      tlen_q       <= tlen_d;
      id_q         <= id_d;
      flag_q       <= flag_d;
      frag_q       <= frag_d;
      ttl_q        <= ttl_d;
      proto_q      <= proto_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      bytes_left_q <= bytes_left_d;
      hdr_cnt_q    <= hdr_cnt_d;
      pkg_data_q   <= pkg_data_d;
      wr_en_q      <= wr_en_d;
      hdr_valid_q  <= hdr_valid_d;
      chk_ok_q     <= chk_ok_d;
      err_q        <= err_d;
      fin_q        <= fin_d;
    end
  end

  assign version        = ver_q;
  assign IHL            = ihl_q;
  assign type_of_ser    = tos_q;
  assign total_len      = tlen_q;
  assign identification = id_q;
  assign flag           = flag_q;
  assign frag_offset    = frag_q;
  assign time_to_live   = ttl_q;
  assign protocol       = proto_q;
  assign src_ip         = src_q;
  assign dest_ip        = dst_q;
  assign len_out        = len_q;
  assign pkg_data       = pkg_data_q;
  assign wr_en          = wr_en_q;
  assign hdr_valid      = hdr_valid_q;
  assign checksum_ok    = chk_ok_q;
  assign err            = err_q;
  assign fin            = fin_q;

endmodule

// File: tb/tb_ip_decoder.sv
// tb_ip_decoder: directed and random IPv4 packets against a packet-level model.
// Expectations follow IP_DEC_CHECKSUM_EN the same way the design build does.
module tb_ip_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        data_av;
  logic [3:0]  version;
  logic [3:0]  IHL;
  logic [7:0]  type_of_ser;
  logic [15:0] total_len;
  logic [15:0] identification;
  logic [2:0]  flag;
  logic [12:0] frag_offset;
  logic [7:0]  time_to_live;
  logic [7:0]  protocol;
  logic [31:0] src_ip;
  logic [31:0] dest_ip;
  logic [15:0] len_out;
  logic [31:0] pkg_data;
  logic        wr_en;
  logic        hdr_valid;
  logic        checksum_ok;
  logic        err;
  logic        fin;

  ip_decoder #(.DROP_ON_ERR(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .data_av        (data_av),
    .version        (version),
    .IHL            (IHL),
    .type_of_ser    (type_of_ser),
    .total_len      (total_len),
    .identification (identification),
    .flag           (flag),
    .frag_offset    (frag_offset),
    .time_to_live   (time_to_live),
    .protocol       (protocol),
    .src_ip         (src_ip),
    .dest_ip        (dest_ip),
    .len_out        (len_out),
    .pkg_data       (pkg_data),
    .wr_en          (wr_en),
    .hdr_valid      (hdr_valid),
    .checksum_ok    (checksum_ok),
    .err            (err),
    .fin            (fin)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Current packet and its expected decode.
  logic [31:0] pw[48];
  int          nw;
  int          hw;
  logic [3:0]  e_ver;
  logic [3:0]  e_ihl;
  logic [7:0]  e_tos;
  logic [15:0] e_tlen;
  logic [15:0] e_id;
  logic [2:0]  e_flag;
  logic [12:0] e_frag;
  logic [7:0]  e_ttl;
  logic [7:0]  e_proto;
  logic [31:0] e_src;
  logic [31:0] e_dst;
  logic [15:0] e_len;
  logic        e_fmt;
  logic        e_csok;
  logic        e_err;
  logic        e_fwd;
  logic [31:0] exp_pkg;

  function automatic logic [15:0] ones_sum(input int n);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < n; i++)
      s = s + {16'h0, pw[i][31:16]} + {16'h0, pw[i][15:0]};
    while (s > 32'hFFFF)
      s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  task automatic build(input int ver, input int ihl,
                       input int paylen, input int tlen_ovr,
                       input bit corrupt, input bit directed);
    logic [15:0] ck;
    int np;
    int tl;
    e_ver = ver[3:0];
    e_ihl = ihl[3:0];
    tl = (tlen_ovr >= 0) ? tlen_ovr : 4 * ihl + paylen;
    e_tlen = tl[15:0];
    if (directed) begin
      e_tos = 8'h00; e_id = 16'h1C46; e_flag = 3'b010;
      e_frag = 13'h0; e_ttl = 8'h40; e_proto = 8'h11;
      e_src = 32'hC0A80001; e_dst = 32'hC0A80002;
    end else begin
      e_tos = 8'($urandom); e_id = 16'($urandom);
      e_flag = 3'($urandom); e_frag = 13'($urandom);
      e_ttl = 8'($urandom); e_proto = 8'($urandom);
      e_src = $urandom; e_dst = $urandom;
    end
    hw = (ihl < 5) ? 5 : ihl;
    pw[0] = {e_ver, e_ihl, e_tos, e_tlen};
    pw[1] = {e_id, e_flag, e_frag};
    pw[2] = {e_ttl, e_proto, 16'h0000};
    pw[3] = e_src;
    pw[4] = e_dst;
    for (int i = 5; i < hw; i++) pw[i] = $urandom;
    ck = ~ones_sum(hw);
    if (corrupt) ck = ck + 16'd1;
    pw[2][15:0] = ck;
`ifdef IP_DEC_CHECKSUM_EN
    e_csok = (ones_sum(hw) == 16'hFFFF);
`else
    e_csok = 1'b1;
`endif
    e_fmt = (ver != 4) || (ihl < 5) || (tl < 4 * ihl);
    e_len = e_fmt ? 16'd0 : 16'(tl - 4 * ihl);
    e_err = e_fmt || !e_csok;
    e_fwd = !e_err;
    np = (int'(e_len) + 3) / 4;
    nw = hw + np;
    for (int i = hw; i < nw; i++) pw[i] = $urandom;
  endtask

  task automatic step(input logic av, input logic [31:0] w);
    data_av = av;
    data_in = w;
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ver"}, {28'h0, version}, 0);
    chk({tag, "_ihl"}, {28'h0, IHL}, 0);
    chk({tag, "_tos"}, {24'h0, type_of_ser}, 0);
    chk({tag, "_tlen"}, {16'h0, total_len}, 0);
    chk({tag, "_id"}, {16'h0, identification}, 0);
    chk({tag, "_flag"}, {29'h0, flag}, 0);
    chk({tag, "_frag"}, {19'h0, frag_offset}, 0);
    chk({tag, "_ttl"}, {24'h0, time_to_live}, 0);
    chk({tag, "_proto"}, {24'h0, protocol}, 0);
    chk({tag, "_src"}, src_ip, 0);
    chk({tag, "_dst"}, dest_ip, 0);
    chk({tag, "_len"}, {16'h0, len_out}, 0);
    chk({tag, "_pkg"}, pkg_data, 0);
    chk({tag, "_wr"}, {31'h0, wr_en}, 0);
    chk({tag, "_hv"}, {31'h0, hdr_valid}, 0);
    chk({tag, "_ck"}, {31'h0, checksum_ok}, 0);
    chk({tag, "_err"}, {31'h0, err}, 0);
    chk({tag, "_fin"}, {31'h0, fin}, 0);
  endtask

  task automatic check_fields();
    chk("ver", {28'h0, version}, {28'h0, e_ver});
    chk("ihl", {28'h0, IHL}, {28'h0, e_ihl});
    chk("tos", {24'h0, type_of_ser}, {24'h0, e_tos});
    chk("tlen", {16'h0, total_len}, {16'h0, e_tlen});
    chk("id", {16'h0, identification}, {16'h0, e_id});
    chk("flag", {29'h0, flag}, {29'h0, e_flag});
    chk("frag", {19'h0, frag_offset}, {19'h0, e_frag});
    chk("ttl", {24'h0, time_to_live}, {24'h0, e_ttl});
    chk("proto", {24'h0, protocol}, {24'h0, e_proto});
    chk("src", src_ip, e_src);
    chk("dst", dest_ip, e_dst);
    chk("len_out", {16'h0, len_out}, {16'h0, e_len});
    chk("cks_hold", {31'h0, checksum_ok}, {31'h0, e_csok});
    chk("err_hold", {31'h0, err}, {31'h0, e_err});
  endtask

  // mode 0: data_av always 1, 1: toggling, 2: random stalls.
  task automatic send(input int mode, input int upto, input bit junk);
    int k;
    int cyc;
    logic av;
    logic ew;
    k = 0;
    cyc = 0;
    while (k < upto && cyc < 4000) begin
      case (mode)
        0:       av = 1'b1;
        1:       av = (cyc % 2 == 0);
        default: av = ($urandom_range(0, 3) != 0);
      endcase
      cyc++;
      step(av, av ? pw[k] : $urandom);
      if (av) begin
        ew = e_fwd && (k >= hw);
        if (ew) exp_pkg = pw[k];
        chk("hdr_valid", {31'h0, hdr_valid}, {31'h0, k == hw - 1});
        chk("wr_en", {31'h0, wr_en}, {31'h0, ew});
        chk("fin", {31'h0, fin}, {31'h0, k == nw - 1});
        if (k == 0) begin
          chk("err_w1", {31'h0, err}, {31'h0, e_fmt});
          chk("cks_w1", {31'h0, checksum_ok}, 0);
        end
        if (k == hw - 1) begin
          chk("cks_hdr", {31'h0, checksum_ok}, {31'h0, e_csok});
          chk("err_hdr", {31'h0, err}, {31'h0, e_err});
          chk("len_hdr", {16'h0, len_out}, {16'h0, e_len});
        end
        k++;
      end else begin
        chk("stall_wr", {31'h0, wr_en}, 0);
        chk("stall_hv", {31'h0, hdr_valid}, 0);
        chk("stall_fin", {31'h0, fin}, 0);
      end
      chk("pkg_data", pkg_data, exp_pkg);
    end
    chk("send_done", k, upto);
    if (upto == nw) begin
      step(junk, $urandom);
      chk("post_wr", {31'h0, wr_en}, 0);
      chk("post_hv", {31'h0, hdr_valid}, 0);
      chk("post_fin", {31'h0, fin}, 0);
      chk("post_pkg", pkg_data, exp_pkg);
      check_fields();
      repeat ($urandom_range(1, 2)) step(1'b0, $urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ver;
    int ihl;
    int pl;
    int tov;
    int kind;
    reset   = 1'b0;
    data_av = 1'b0;
    data_in = '0;
    exp_pkg = '0;
    repeat (2) @(negedge clk);
    check_zero("rst");
    reset = 1'b1;
    step(1'b0, 0);

    build(4, 5, 12, -1, 1'b0, 1'b1);
    chk("dir_w1", pw[0], 32'h45000020);
    send(0, nw, 1'b0);
    build(4, 5, 12, -1, 1'b0, 1'b1);
    send(1, nw, 1'b0);
    build(4, 5, 12, -1, 1'b1, 1'b1);
    send(0, nw, 1'b1);
    build(4, 6, 2, -1, 1'b0, 1'b0);
    chk("opt_tlen", {16'h0, e_tlen}, 32'h1A);
    send(2, nw, 1'b0);
    build(6, 5, 0, -1, 1'b0, 1'b1);
    chk("v6_w1", pw[0], 32'h65000014);
    send(0, nw, 1'b1);

    build(4, 5, 12, -1, 1'b0, 1'b1);
    send(0, 6, 1'b0);
    #2 reset = 1'b0;
    #1 check_zero("mid_rst");
    @(negedge clk);
    chk("mid_rst_fin", {31'h0, fin}, 0);
    reset = 1'b1;
    exp_pkg = '0;
    step(1'b0, 0);
    build(4, 7, 9, -1, 1'b0, 1'b0);
    send(2, nw, 1'b0);

    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 9);
      ver = 4;
      ihl = $urandom_range(5, 8);
      pl = $urandom_range(0, 20);
      tov = -1;
      if (kind == 0) ver = $urandom_range(0, 15);
      if (kind == 1) ihl = $urandom_range(0, 4);
      if (kind == 2) tov = $urandom_range(0, 4 * ihl - 1);
      build(ver, ihl, pl, tov, kind >= 7, 1'b0);
      send($urandom_range(0, 2), nw, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
